// File: rtl/load_store_buffer_if.sv
// Dispatch, result-broadcast and LS-issue signals of the load/store buffer.
// The buffer uses the slave view; the dispatch/CDB/LS-unit side uses the master view.
interface load_store_buffer_if;
    logic        rdy;

    logic        disp_valid;
    logic [5:0]  disp_op_id;
    logic [31:0] disp_pc;
    logic        disp_rs1_rdy;
    logic [31:0] disp_rs1_val;
    logic [3:0]  disp_rs1_tag;
    logic        disp_rs2_rdy;
    logic [31:0] disp_rs2_val;
    logic [3:0]  disp_rs2_tag;
    logic [31:0] disp_imm;
    logic [3:0]  disp_rob_id;
    logic        lsb_full;

    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_rob_id;
    logic [31:0] alu_cdb_value;
    logic        ls_cdb_valid;
    logic [3:0]  ls_cdb_rob_id;
    logic [31:0] ls_cdb_value;

    logic        ls_enable;
    logic        ls_issue_valid;
    logic [5:0]  ls_op_id;
    logic [31:0] ls_inst_pc;
    logic [31:0] ls_rs1;
    logic [31:0] ls_rs2;
    logic [31:0] ls_imm;
    logic [3:0]  ls_rob_id;

    logic        rob_roll_back;

    modport slave (
        input  rdy,
        input  disp_valid, disp_op_id, disp_pc,
        input  disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
        input  disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
        input  disp_imm, disp_rob_id,
        output lsb_full,
        input  alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
        input  ls_cdb_valid, ls_cdb_rob_id, ls_cdb_value,
        input  ls_enable,
        output ls_issue_valid, ls_op_id, ls_inst_pc, ls_rs1, ls_rs2, ls_imm, ls_rob_id,
        input  rob_roll_back
    );

    modport master (
        output rdy,
        output disp_valid, disp_op_id, disp_pc,
        output disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
        output disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
        output disp_imm, disp_rob_id,
        input  lsb_full,
        output alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
        output ls_cdb_valid, ls_cdb_rob_id, ls_cdb_value,
        output ls_enable,
        input  ls_issue_valid, ls_op_id, ls_inst_pc, ls_rs1, ls_rs2, ls_imm, ls_rob_id,
        output rob_roll_back
    );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: holds dispatched memory ops, snoops both CDBs for
// missing operands, and issues the oldest entry to the LS unit once it is ready.
module load_store_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_buffer_if.slave    bus
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0] head_q, tail_q;
    logic [IDX_W:0]   count_q, count_d;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] rs1_rdy_q, rs2_rdy_q;
    logic [5:0]       op_q      [DEPTH];
    logic [31:0]      pc_q      [DEPTH];
    logic [31:0]      imm_q     [DEPTH];
    logic [3:0]       rob_q     [DEPTH];
    logic [31:0]      rs1_val_q [DEPTH];
    logic [31:0]      rs2_val_q [DEPTH];
    logic [3:0]       rs1_tag_q [DEPTH];
    logic [3:0]       rs2_tag_q [DEPTH];

    logic        ls_valid_q;
    logic [5:0]  ls_op_q;
    logic [31:0] ls_pc_q, ls_rs1_q, ls_rs2_q, ls_imm_q;
    logic [3:0]  ls_rob_q;

    logic full, disp_go, issue_go;

    assign full     = (count_q == FULL_CNT);
    assign disp_go  = bus.disp_valid && !full;
    // Issue looks only at registered state, so a CDB hit this cycle issues next cycle at the earliest.
    assign issue_go = busy_q[head_q] && rs1_rdy_q[head_q] && rs2_rdy_q[head_q] && bus.ls_enable;

    // Per-entry CDB match; ALU value takes precedence when both buses carry the tag.
    logic [DEPTH-1:0] rs1_hit, rs2_hit;
    logic [31:0]      rs1_snoop [DEPTH];
    logic [31:0]      rs2_snoop [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
            logic a1, l1, a2, l2;
            assign a1 = bus.alu_cdb_valid && (bus.alu_cdb_rob_id == rs1_tag_q[gi]);
            assign l1 = bus.ls_cdb_valid  && (bus.ls_cdb_rob_id  == rs1_tag_q[gi]);
            assign a2 = bus.alu_cdb_valid && (bus.alu_cdb_rob_id == rs2_tag_q[gi]);
            assign l2 = bus.ls_cdb_valid  && (bus.ls_cdb_rob_id  == rs2_tag_q[gi]);
            assign rs1_hit[gi]   = busy_q[gi] && !rs1_rdy_q[gi] && (a1 || l1);
            assign rs2_hit[gi]   = busy_q[gi] && !rs2_rdy_q[gi] && (a2 || l2);
            assign rs1_snoop[gi] = a1 ? bus.alu_cdb_value : bus.ls_cdb_value;
            assign rs2_snoop[gi] = a2 ? bus.alu_cdb_value : bus.ls_cdb_value;
        end
    endgenerate

    // Same-cycle bypass for the entry being dispatched.
    logic        byp1_rdy, byp2_rdy;
    logic [31:0] byp1_val, byp2_val;

    always_comb begin
        byp1_rdy = bus.disp_rs1_rdy;
        byp1_val = bus.disp_rs1_val;
        byp2_rdy = bus.disp_rs2_rdy;
        byp2_val = bus.disp_rs2_val;
        if (!bus.disp_rs1_rdy) begin
            if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.disp_rs1_tag) begin
                byp1_rdy = 1'b1;
                byp1_val = bus.alu_cdb_value;
            end else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == bus.disp_rs1_tag) begin
                byp1_rdy = 1'b1;
                byp1_val = bus.ls_cdb_value;
            end
        end
        if (!bus.disp_rs2_rdy) begin
            if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == bus.disp_rs2_tag) begin
                byp2_rdy = 1'b1;
                byp2_val = bus.alu_cdb_value;
            end else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == bus.disp_rs2_tag) begin
                byp2_rdy = 1'b1;
                byp2_val = bus.ls_cdb_value;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({disp_go, issue_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ls_valid_q <= 1'b0;
            ls_op_q    <= '0;
            ls_pc_q    <= '0;
            ls_rs1_q   <= '0;
            ls_rs2_q   <= '0;
            ls_imm_q   <= '0;
            ls_rob_q   <= '0;
        end else if (bus.rdy) begin
            if (bus.rob_roll_back) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                busy_q     <= '0;
                ls_valid_q <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rs1_hit[i]) begin
                        rs1_rdy_q[i] <= 1'b1;
                        rs1_val_q[i] <= rs1_snoop[i];
                    end
                    if (rs2_hit[i]) begin
                        rs2_rdy_q[i] <= 1'b1;
                        rs2_val_q[i] <= rs2_snoop[i];
                    end
                end

                ls_valid_q <= issue_go;
                if (issue_go) begin
                    ls_op_q        <= op_q[head_q];
                    ls_pc_q        <= pc_q[head_q];
                    ls_rs1_q       <= rs1_val_q[head_q];
                    ls_rs2_q       <= rs2_val_q[head_q];
                    ls_imm_q       <= imm_q[head_q];
                    ls_rob_q       <= rob_q[head_q];
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end

                // The slot at tail is never busy when not full, so it cannot collide with the snoop above.
                if (disp_go) begin
                    busy_q[tail_q]    <= 1'b1;
                    op_q[tail_q]      <= bus.disp_op_id;
                    pc_q[tail_q]      <= bus.disp_pc;
                    imm_q[tail_q]     <= bus.disp_imm;
                    rob_q[tail_q]     <= bus.disp_rob_id;
                    rs1_rdy_q[tail_q] <= byp1_rdy;
                    rs1_val_q[tail_q] <= byp1_val;
                    rs1_tag_q[tail_q] <= bus.disp_rs1_tag;
                    rs2_rdy_q[tail_q] <= byp2_rdy;
                    rs2_val_q[tail_q] <= byp2_val;
                    rs2_tag_q[tail_q] <= bus.disp_rs2_tag;
                    tail_q            <= tail_q + 1'b1;
                end

                count_q <= count_d;
            end
        end
    end

    assign bus.lsb_full       = full;
    assign bus.ls_issue_valid = ls_valid_q;
    assign bus.ls_op_id       = ls_op_q;
    assign bus.ls_inst_pc     = ls_pc_q;
    assign bus.ls_rs1         = ls_rs1_q;
    assign bus.ls_rs2         = ls_rs2_q;
    assign bus.ls_imm         = ls_imm_q;
    assign bus.ls_rob_id      = ls_rob_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_load_store_buffer;

    logic clk;
    logic rst;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;
    bit   chk_en;

    load_store_buffer_if bus ();

    load_store_buffer #(.DEPTH(16), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  rob;
        logic        r1;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic        r2;
        logic [31:0] v2;
        logic [3:0]  t2;
    } ent_t;

    ent_t        mq[$];
    ent_t        mdl_h, mdl_e;
    bit          mdl_go, mdl_was_full;
    logic [32:0] mdl_tmp;
    logic        exp_valid;
    ent_t        exp_ent;

    function automatic logic [32:0] snoop(input logic r, input logic [31:0] v, input logic [3:0] t);
        if (r) return {1'b1, v};
        if (bus.alu_cdb_valid && bus.alu_cdb_rob_id == t) return {1'b1, bus.alu_cdb_value};
        if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == t) return {1'b1, bus.ls_cdb_value};
        return {1'b0, v};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_ent   = '0;
        end else if (bus.rdy) begin
            if (bus.rob_roll_back) begin
                mq.delete();
                exp_valid = 1'b0;
            end else begin
                mdl_was_full = (mq.size() == 16);
                mdl_go = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && bus.ls_enable;
                if (mdl_go) mdl_h = mq[0];
                foreach (mq[i]) begin
                    mdl_tmp = snoop(mq[i].r1, mq[i].v1, mq[i].t1);
                    mq[i].r1 = mdl_tmp[32];
                    mq[i].v1 = mdl_tmp[31:0];
                    mdl_tmp = snoop(mq[i].r2, mq[i].v2, mq[i].t2);
                    mq[i].r2 = mdl_tmp[32];
                    mq[i].v2 = mdl_tmp[31:0];
                end
                if (mdl_go) begin
                    void'(mq.pop_front());
                    exp_valid = 1'b1;
                    exp_ent   = mdl_h;
                end else begin
                    exp_valid = 1'b0;
                end
                if (bus.disp_valid && !mdl_was_full) begin
                    mdl_e.op  = bus.disp_op_id;
                    mdl_e.pc  = bus.disp_pc;
                    mdl_e.imm = bus.disp_imm;
                    mdl_e.rob = bus.disp_rob_id;
                    mdl_e.t1  = bus.disp_rs1_tag;
                    mdl_e.t2  = bus.disp_rs2_tag;
                    mdl_tmp = snoop(bus.disp_rs1_rdy, bus.disp_rs1_val, bus.disp_rs1_tag);
                    mdl_e.r1 = mdl_tmp[32];
                    mdl_e.v1 = mdl_tmp[31:0];
                    mdl_tmp = snoop(bus.disp_rs2_rdy, bus.disp_rs2_val, bus.disp_rs2_tag);
                    mdl_e.r2 = mdl_tmp[32];
                    mdl_e.v2 = mdl_tmp[31:0];
                    mq.push_back(mdl_e);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("issue_valid", 32'(bus.ls_issue_valid), 32'(exp_valid));
            chk("lsb_full", 32'(bus.lsb_full), 32'(mq.size() == 16));
            if (exp_valid) begin
                chk("ls_op_id",   32'(bus.ls_op_id),  32'(exp_ent.op));
                chk("ls_inst_pc", bus.ls_inst_pc,     exp_ent.pc);
                chk("ls_rs1",     bus.ls_rs1,         exp_ent.v1);
                chk("ls_rs2",     bus.ls_rs2,         exp_ent.v2);
                chk("ls_imm",     bus.ls_imm,         exp_ent.imm);
                chk("ls_rob_id",  32'(bus.ls_rob_id), 32'(exp_ent.rob));
            end
        end
    end

    // ---------------- issue log ----------------
    typedef struct packed {
        int          cyc;
        logic [3:0]  rob;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } rec_t;

    rec_t ilog[$];

    always @(negedge clk) begin
        if (chk_en && bus.ls_issue_valid === 1'b1) begin
            ilog.push_back('{cyc: cyc, rob: bus.ls_rob_id, rs1: bus.ls_rs1, rs2: bus.ls_rs2, imm: bus.ls_imm});
            $display("issue cyc=%0d rob=%0d op=%0d pc=0x%0h rs1=0x%0h rs2=0x%0h imm=0x%0h",
                     cyc, bus.ls_rob_id, bus.ls_op_id, bus.ls_inst_pc, bus.ls_rs1, bus.ls_rs2, bus.ls_imm);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.ls_cdb_valid  = 1'b0;
        bus.rob_roll_back = 1'b0;
        bus.rdy           = 1'b1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                        input logic [31:0] imm);
        bus.disp_valid   = 1'b1;
        bus.disp_op_id   = op;
        bus.disp_pc      = 32'h1000 + 32'(rob) * 4;
        bus.disp_rob_id  = rob;
        bus.disp_rs1_rdy = r1;
        bus.disp_rs1_val = v1;
        bus.disp_rs1_tag = t1;
        bus.disp_rs2_rdy = r2;
        bus.disp_rs2_val = v2;
        bus.disp_rs2_tag = t2;
        bus.disp_imm     = imm;
    endtask

    task automatic wait_issue(input string name, input int budget, output rec_t r);
        int n;
        n = 0;
        while (ilog.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        if (ilog.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: no issue within %0d cycles, required one", name, budget);
            r = '0;
        end else begin
            r = ilog.pop_front();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [5:0] OP_LW = 6'd2;
    localparam logic [5:0] OP_SW = 6'd7;

    initial begin
        rec_t r;
        int   d0, n0;

        cyc = 0; pass_cnt = 0; total_cnt = 0; chk_en = 1'b0;
        idle();
        bus.ls_enable = 1'b0;
        disp(OP_LW, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        bus.disp_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_issue_valid", 32'(bus.ls_issue_valid), 32'd0);
        chk("rst_full",        32'(bus.lsb_full),       32'd0);
        chk("rst_rs1",         bus.ls_rs1,              32'd0);
        chk("rst_rob",         32'(bus.ls_rob_id),      32'd0);
        rst = 1'b0;

        // Ready LW issues two cycles after dispatch.
        bus.ls_enable = 1'b1;
        disp(OP_LW, 4'd3, 1'b1, 32'h100, 4'd0, 1'b1, 32'h0, 4'd0, 32'd4);
        d0 = cyc;
        tick(); idle();
        wait_issue("t1_issue", 10, r);
        chk("t1_latency", 32'(r.cyc - d0), 32'd2);
        chk("t1_rs1", r.rs1, 32'h100);
        chk("t1_imm", r.imm, 32'd4);
        chk("t1_rob", 32'(r.rob), 32'd3);
        tick();
        chk("t1_model_count", 32'(mq.size()), 32'd0);

        // SW waits on ALU broadcast of rob 2 three cycles later.
        disp(OP_SW, 4'd5, 1'b0, 32'h0, 4'd2, 1'b1, 32'h55, 4'd0, 32'd8);
        tick(); idle();
        tick(); tick();
        bus.alu_cdb_valid  = 1'b1;
        bus.alu_cdb_rob_id = 4'd2;
        bus.alu_cdb_value  = 32'h2000;
        n0 = cyc;
        chk("t2_no_early", 32'(ilog.size()), 32'd0);
        tick(); idle();
        wait_issue("t2_issue", 10, r);
        chk("t2_latency", 32'(r.cyc - n0), 32'd2);
        chk("t2_rs1", r.rs1, 32'h2000);
        chk("t2_rs2", r.rs2, 32'h55);
        chk("t2_rob", 32'(r.rob), 32'd5);

        // Same-cycle LS CDB bypass into dispatch.
        disp(OP_LW, 4'd9, 1'b1, 32'h40, 4'd0, 1'b0, 32'h0, 4'd7, 32'd0);
        bus.ls_cdb_valid  = 1'b1;
        bus.ls_cdb_rob_id = 4'd7;
        bus.ls_cdb_value  = 32'hDEAD;
        tick(); idle();
        wait_issue("t3_issue", 10, r);
        chk("t3_rs2", r.rs2, 32'hDEAD);
        chk("t3_rob", 32'(r.rob), 32'd9);

        // Fill, overflow drop, drain in order; second fill crosses the pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            bus.ls_enable = 1'b0;
            for (int i = 0; i < 16; i++) begin
                disp(OP_LW, 4'((pass == 0) ? i : 15 - i), 1'b1, 32'(i * 16), 4'd0, 1'b1, 32'd1, 4'd0, 32'd0);
                tick();
            end
            idle();
            chk("t4_full", 32'(bus.lsb_full), 32'd1);
            disp(OP_SW, 4'hA, 1'b1, 32'hBAD, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
            tick(); idle();
            chk("t4_full_after_drop", 32'(bus.lsb_full), 32'd1);
            bus.ls_enable = 1'b1;
            for (int i = 0; i < 16; i++) begin
                wait_issue("t4_issue", 6, r);
                chk("t4_order", 32'(r.rob), 32'((pass == 0) ? i : 15 - i));
                chk("t4_rs1", r.rs1, 32'(i * 16));
            end
            tick(); tick(); tick();
            chk("t4_no_extra", 32'(ilog.size()), 32'd0);
            chk("t4_empty", 32'(bus.lsb_full), 32'd0);
        end

        // Non-ready head blocks a ready younger entry.
        disp(OP_LW, 4'd1, 1'b0, 32'h0, 4'd4, 1'b1, 32'd0, 4'd0, 32'd0);
        tick();
        disp(OP_SW, 4'd2, 1'b1, 32'h22, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        tick(); idle();
        repeat (4) tick();
        chk("t5_blocked", 32'(ilog.size()), 32'd0);
        bus.alu_cdb_valid  = 1'b1;
        bus.alu_cdb_rob_id = 4'd4;
        bus.alu_cdb_value  = 32'h44;
        tick(); idle();
        wait_issue("t5_head", 10, r);
        chk("t5_head_rob", 32'(r.rob), 32'd1);
        chk("t5_head_rs1", r.rs1, 32'h44);
        wait_issue("t5_second", 10, r);
        chk("t5_second_rob", 32'(r.rob), 32'd2);

        // Rollback with five entries and a simultaneous dispatch.
        bus.ls_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(OP_LW, 4'(i), 1'b1, 32'(i), 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
            tick();
        end
        disp(OP_LW, 4'd6, 1'b1, 32'h6, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        bus.rob_roll_back = 1'b1;
        tick(); idle();
        chk("t6_full", 32'(bus.lsb_full), 32'd0);
        chk("t6_no_issue", 32'(bus.ls_issue_valid), 32'd0);
        chk("t6_model_count", 32'(mq.size()), 32'd0);
        bus.ls_enable = 1'b1;
        repeat (3) tick();
        chk("t6_nothing_left", 32'(ilog.size()), 32'd0);
        disp(OP_SW, 4'hC, 1'b1, 32'hC0, 4'd0, 1'b1, 32'hC1, 4'd0, 32'd0);
        tick(); idle();
        wait_issue("t6_after", 10, r);
        chk("t6_after_rob", 32'(r.rob), 32'hC);

        // Randomized traffic, checked every cycle by the compare process.
        for (int k = 0; k < 800; k++) begin
            bus.rdy           = ($urandom_range(0, 9) != 0);
            bus.ls_enable     = $urandom_range(0, 1) == 1;
            bus.rob_roll_back = ($urandom_range(0, 99) == 0);
            disp(6'($urandom), 4'($urandom), $urandom_range(0, 2) != 0, $urandom,
                 4'($urandom), $urandom_range(0, 2) != 0, $urandom, 4'($urandom), $urandom);
            bus.disp_valid     = $urandom_range(0, 1) == 1;
            bus.alu_cdb_valid  = $urandom_range(0, 2) == 0;
            bus.alu_cdb_rob_id = 4'($urandom);
            bus.alu_cdb_value  = $urandom;
            bus.ls_cdb_valid   = $urandom_range(0, 2) == 0;
            bus.ls_cdb_rob_id  = 4'($urandom);
            bus.ls_cdb_value   = $urandom;
            if (bus.alu_cdb_valid && bus.ls_cdb_rob_id == bus.alu_cdb_rob_id)
                bus.ls_cdb_valid = 1'b0;
            tick();
        end
        idle();
        bus.rob_roll_back = 1'b1;
        tick();
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
